neuron_unit: RTL and testbench

//  Ising/simulated-annealing spiking neuron. It holds a membrane value Vmem, a spin bit and an FP16

---
 rtl/neuron_unit.sv | 181 ++++++++++++++++++
 tb/tb_neuron_unit.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/neuron_unit.sv
// Ising/annealing spiking neuron: holds Vmem, spin, FP16 threshold mu and a ternary coupling row Q.
// Requests a spin flip when Vmem > mu and folds network spikes into Vmem as 2*spike*J[src].
module neuron_unit #(
  parameter int FP_DATA_WIDTH   = 16,
  parameter int TEN_DATA_WIDTH  = 2,
  parameter int NUM_NEURON      = 64,
  parameter int NEURON_ID_WIDTH = 10
) (
  input  logic                                      clk,
  input  logic                                      reset_l,
  input  logic                                      en_neuron,
  input  logic                                      en_spike,
  input  logic                                      wrVmem,
  input  logic                                      wrNeuronI,
  input  logic                                      wrMu,
  input  logic                                      wrQ,
  input  logic [NEURON_ID_WIDTH-1:0]                neuronI_in,
  input  logic [FP_DATA_WIDTH-1:0]                  Vmem_in,
  input  logic [TEN_DATA_WIDTH-1:0]                 Q_in,
  input  logic [FP_DATA_WIDTH-1:0]                  mu_in,
  input  logic [TEN_DATA_WIDTH+NEURON_ID_WIDTH-1:0] spike_in,
  input  logic                                      networkDone,
  output logic [FP_DATA_WIDTH-1:0]                  mu_out,
  output logic [TEN_DATA_WIDTH-1:0]                 spike_out,
  output logic                                      neuronWrDone
);

  localparam int CNT_W = $clog2(NUM_NEURON);
  localparam int SPK_W = TEN_DATA_WIDTH + NEURON_ID_WIDTH;
  localparam logic signed [FP_DATA_WIDTH:0] VMAX = (FP_DATA_WIDTH+1)'((1 << (FP_DATA_WIDTH-1)) - 1);
  localparam logic signed [FP_DATA_WIDTH:0] VMIN = -(FP_DATA_WIDTH+1)'(1 << (FP_DATA_WIDTH-1));

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CONFIG  = 3'd1,
    EMIT    = 3'd2,
    NETWORK = 3'd3,
    RECV1   = 3'd4,
    RECV2   = 3'd5
  } state_t;

  state_t                            state;
  logic signed [FP_DATA_WIDTH-1:0]   vmem_q;
  logic [FP_DATA_WIDTH-1:0]          mu_q;
  logic [NEURON_ID_WIDTH-1:0]        neuron_id_q;
  logic                              spin_q;
  logic [TEN_DATA_WIDTH-1:0]         q_mem [NUM_NEURON];
  logic [CNT_W-1:0]                  cnt;
  logic [SPK_W-1:0]                  spike_q;
  logic signed [2:0]                 dvmem_p1;
  logic [TEN_DATA_WIDTH-1:0]         spike_out_q;
  logic                              wr_done_q;

  logic                              fire;
  logic                              no_strobe;
  logic [NEURON_ID_WIDTH-1:0]        src_id;
  logic [TEN_DATA_WIDTH-1:0]         spk_ten;
  logic [TEN_DATA_WIDTH-1:0]         coupling;
  logic signed [1:0]                 prod;
  logic signed [FP_DATA_WIDTH:0]     vsum;

  function automatic logic signed [1:0] tern_val(input logic [TEN_DATA_WIDTH-1:0] code);
    case (code)
      2'b01:   return 2'sd1;
      2'b10:   return -2'sd1;
      default: return 2'sd0;
    endcase
  endfunction

  function automatic logic signed [FP_DATA_WIDTH-1:0] sat16(input logic signed [FP_DATA_WIDTH:0] sum);
    if (sum > VMAX) return VMAX[FP_DATA_WIDTH-1:0];
    if (sum < VMIN) return VMIN[FP_DATA_WIDTH-1:0];
    return sum[FP_DATA_WIDTH-1:0];
  endfunction

  // Exact Vmem > mu: scale |mu| by 2^24 so every finite half lands on an integer, then
  // fold the fractional part into the integer threshold (V > -(i+f) <=> V >= -i for f != 0).
  function automatic logic fp_gt(input logic signed [15:0] v, input logic [15:0] mu);
    logic [4:0]         ex;
    logic [9:0]         fr;
    logic [10:0]        mant;
    logic [4:0]         sh;
    logic [39:0]        fixed;
    logic [15:0]        ip;
    logic               fnz;
    logic signed [17:0] thr;
    logic signed [17:0] vx;
    ex    = mu[14:10];
    fr    = mu[9:0];
    mant  = {|ex, fr};
    sh    = (ex == 5'd0) ? 5'd0 : ex - 5'd1;
    fixed = {29'd0, mant} << sh;
    ip    = fixed[39:24];
    fnz   = |fixed[23:0];
    vx    = 18'(v);
    thr   = $signed({2'b00, ip});
    if (mu[15]) thr = -thr - $signed({17'd0, fnz});
    if (ex == 5'h1f) return (fr == 10'd0) && mu[15];
    return vx > thr;
  endfunction

  always_comb begin
    fire      = fp_gt(vmem_q, mu_q);
    no_strobe = !(wrVmem || wrNeuronI || wrMu || wrQ);
    src_id    = spike_q[NEURON_ID_WIDTH-1:0];
    spk_ten   = spike_q[SPK_W-1 -: TEN_DATA_WIDTH];
    coupling  = (src_id < NEURON_ID_WIDTH'(NUM_NEURON)) ? q_mem[src_id[CNT_W-1:0]] : '0;
    prod      = tern_val(spk_ten) * tern_val(coupling);
    vsum      = (FP_DATA_WIDTH+1)'(vmem_q) + (FP_DATA_WIDTH+1)'(dvmem_p1);
  end

  always_ff @(posedge clk) begin
    if (reset_l) begin
      state       <= IDLE;
      vmem_q      <= '0;
      mu_q        <= '0;
      neuron_id_q <= '0;
      spin_q      <= 1'b0;
      cnt         <= '0;
      spike_q     <= '0;
      dvmem_p1    <= '0;
      spike_out_q <= '0;
      wr_done_q   <= 1'b0;
      for (int i = 0; i < NUM_NEURON; i++) q_mem[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (en_neuron) state <= CONFIG;
        end
        CONFIG: begin
          if (wrVmem)    vmem_q      <= $signed(Vmem_in);
          if (wrNeuronI) neuron_id_q <= neuronI_in;
          if (wrMu)      mu_q        <= mu_in;
          if (wrQ) begin
            q_mem[cnt] <= Q_in;
            if (cnt == CNT_W'(NUM_NEURON - 1)) begin
              cnt       <= '0;
              wr_done_q <= 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          if (!en_neuron)                 state <= IDLE;
          else if (en_spike && no_strobe) state <= EMIT;
        end
        EMIT: begin
          spike_out_q <= fire ? (spin_q ? 2'b10 : 2'b01) : 2'b00;
          state       <= NETWORK;
        end
        NETWORK: begin
          if (networkDone) begin
            spike_q     <= spike_in;
            mu_q        <= mu_in;
            spike_out_q <= '0;
            state       <= RECV1;
          end
        end
        // stage 1: coupling lookup -> dvmem_p1, self-spike updates the spin
        RECV1: begin
          dvmem_p1 <= $signed({prod, 1'b0});
          if (src_id == neuron_id_q) begin
            if (spk_ten == 2'b01)      spin_q <= 1'b1;
            else if (spk_ten == 2'b10) spin_q <= 1'b0;
          end
          state <= RECV2;
        end
        // stage 2: saturating membrane update
        RECV2: begin
          vmem_q <= sat16(vsum);
          state  <= en_spike ? EMIT : CONFIG;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign mu_out       = mu_q;
  assign spike_out    = spike_out_q;
  assign neuronWrDone = wr_done_q;

endmodule

// File: tb/tb_neuron_unit.sv
// Directed bench for neuron_unit: configuration, Q loading, fire/emit, spike accumulation,
// saturation, threshold special values and mid-operation reset.
module tb_neuron_unit;

  logic        clk;
  logic        reset_l;
  logic        en_neuron;
  logic        en_spike;
  logic        wrVmem;
  logic        wrNeuronI;
  logic        wrMu;
  logic        wrQ;
  logic [9:0]  neuronI_in;
  logic [15:0] Vmem_in;
  logic [1:0]  Q_in;
  logic [15:0] mu_in;
  logic [11:0] spike_in;
  logic        networkDone;
  logic [15:0] mu_out;
  logic [1:0]  spike_out;
  logic        neuronWrDone;

  int tests;
  int failed;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_CONFIG  = 3'd1;
  localparam logic [2:0] S_EMIT    = 3'd2;
  localparam logic [2:0] S_NETWORK = 3'd3;
  localparam logic [2:0] S_RECV1   = 3'd4;
  localparam logic [2:0] S_RECV2   = 3'd5;

  neuron_unit dut (
    .clk(clk), .reset_l(reset_l), .en_neuron(en_neuron), .en_spike(en_spike),
    .wrVmem(wrVmem), .wrNeuronI(wrNeuronI), .wrMu(wrMu), .wrQ(wrQ),
    .neuronI_in(neuronI_in), .Vmem_in(Vmem_in), .Q_in(Q_in), .mu_in(mu_in),
    .spike_in(spike_in), .networkDone(networkDone), .mu_out(mu_out),
    .spike_out(spike_out), .neuronWrDone(neuronWrDone)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_l = 1'b1; en_neuron = 1'b0; en_spike = 1'b0;
    wrVmem = 1'b0; wrNeuronI = 1'b0; wrMu = 1'b0; wrQ = 1'b0;
    neuronI_in = '0; Vmem_in = '0; Q_in = '0; mu_in = '0; spike_in = '0; networkDone = 1'b0;
    step(); step();
    tests++; if (mu_out !== 16'h0) begin failed++; $display("FAIL reset_mu_out: got %h want 0000", mu_out); end
    tests++; if (spike_out !== 2'b00) begin failed++; $display("FAIL reset_spike_out: got %b want 00", spike_out); end
    tests++; if (neuronWrDone !== 1'b0) begin failed++; $display("FAIL reset_wrdone: got %b want 0", neuronWrDone); end
    tests++; if (dut.state !== S_IDLE) begin failed++; $display("FAIL reset_state: got %0d want %0d", dut.state, S_IDLE); end
    reset_l = 1'b0;
  endtask

  task automatic test_config();
    en_neuron = 1'b1;
    step();
    tests++; if (dut.state !== S_CONFIG) begin failed++; $display("FAIL cfg_state: got %0d want %0d", dut.state, S_CONFIG); end
    wrVmem = 1'b1; Vmem_in = 16'h0068;
    wrNeuronI = 1'b1; neuronI_in = 10'h03A;
    wrMu = 1'b1; mu_in = 16'h5678;
    step();
    wrVmem = 1'b0; wrNeuronI = 1'b0; wrMu = 1'b0;
    tests++; if (dut.vmem_q !== 16'sd104) begin failed++; $display("FAIL cfg_vmem: got %0d want 104", dut.vmem_q); end
    tests++; if (dut.neuron_id_q !== 10'h03A) begin failed++; $display("FAIL cfg_id: got %h want 03a", dut.neuron_id_q); end
    tests++; if (mu_out !== 16'h5678) begin failed++; $display("FAIL cfg_mu_out: got %h want 5678", mu_out); end
  endtask

  task automatic test_wrq();
    wrQ = 1'b1;
    for (int i = 0; i < 64; i++) begin
      Q_in = (i == 58) ? 2'd0 : 2'(i % 3);
      step();
      if (i == 62) begin
        tests++; if (neuronWrDone !== 1'b0) begin failed++; $display("FAIL wrq_done_early: got %b want 0", neuronWrDone); end
      end
    end
    wrQ = 1'b0;
    tests++; if (neuronWrDone !== 1'b1) begin failed++; $display("FAIL wrq_done: got %b want 1", neuronWrDone); end
    tests++; if (dut.q_mem[13] !== 2'b01) begin failed++; $display("FAIL wrq_q13: got %b want 01", dut.q_mem[13]); end
    tests++; if (dut.q_mem[58] !== 2'b00) begin failed++; $display("FAIL wrq_q58: got %b want 00", dut.q_mem[58]); end
    tests++; if (dut.q_mem[2] !== 2'b10) begin failed++; $display("FAIL wrq_q2: got %b want 10", dut.q_mem[2]); end
  endtask

  task automatic test_emit();
    en_spike = 1'b1;
    step();
    tests++; if (dut.state !== S_EMIT) begin failed++; $display("FAIL emit_state: got %0d want %0d", dut.state, S_EMIT); end
    step();
    // 104 > 103.5 with spin 0
    tests++; if (spike_out !== 2'b01) begin failed++; $display("FAIL emit_spike: got %b want 01", spike_out); end
    step();
    tests++; if (spike_out !== 2'b01 || dut.state !== S_NETWORK) begin failed++; $display("FAIL emit_hold: got %b/%0d want 01/%0d", spike_out, dut.state, S_NETWORK); end
  endtask

  task automatic test_recv_neg();
    networkDone = 1'b1; spike_in = {2'b10, 10'd13}; mu_in = 16'h5668;
    step();
    networkDone = 1'b0;
    tests++; if (spike_out !== 2'b00) begin failed++; $display("FAIL neg_spike_clr: got %b want 00", spike_out); end
    tests++; if (mu_out !== 16'h5668) begin failed++; $display("FAIL neg_mu: got %h want 5668", mu_out); end
    tests++; if (dut.vmem_q !== 16'sd104) begin failed++; $display("FAIL neg_vmem_early: got %0d want 104", dut.vmem_q); end
    step();
    tests++; if (dut.dvmem_p1 !== -3'sd2) begin failed++; $display("FAIL neg_dvmem: got %0d want -2", dut.dvmem_p1); end
    step();
    tests++; if (dut.vmem_q !== 16'sd102 || dut.state !== S_EMIT) begin failed++; $display("FAIL neg_vmem: got %0d/%0d want 102/%0d", dut.vmem_q, dut.state, S_EMIT); end
    step();
    // 102 > 102.5 is false
    tests++; if (spike_out !== 2'b00) begin failed++; $display("FAIL neg_fire: got %b want 00", spike_out); end
  endtask

  task automatic test_self_spike();
    networkDone = 1'b1; spike_in = {2'b01, 10'h03A}; mu_in = 16'h5664;
    step();
    networkDone = 1'b0;
    step();
    tests++; if (dut.dvmem_p1 !== 3'sd0) begin failed++; $display("FAIL self_dvmem: got %0d want 0", dut.dvmem_p1); end
    tests++; if (dut.spin_q !== 1'b1) begin failed++; $display("FAIL self_spin: got %b want 1", dut.spin_q); end
    step();
    tests++; if (dut.vmem_q !== 16'sd102) begin failed++; $display("FAIL self_vmem: got %0d want 102", dut.vmem_q); end
    step();
    tests++; if (spike_out !== 2'b00) begin failed++; $display("FAIL self_fire: got %b want 00", spike_out); end
  endtask

  task automatic test_saturation();
    // neutral round, drop back to CONFIG
    en_spike = 1'b0;
    networkDone = 1'b1; spike_in = {2'b00, 10'd13}; mu_in = 16'h5678;
    step();
    networkDone = 1'b0;
    step(); step();
    tests++; if (dut.state !== S_CONFIG) begin failed++; $display("FAIL sat_cfg_state: got %0d want %0d", dut.state, S_CONFIG); end
    wrVmem = 1'b1; Vmem_in = 16'h7FFF;
    step();
    wrVmem = 1'b0; en_spike = 1'b1;
    step(); step();
    tests++; if (spike_out !== 2'b10) begin failed++; $display("FAIL sat_spin1_fire: got %b want 10", spike_out); end
    networkDone = 1'b1; spike_in = {2'b01, 10'd1}; mu_in = 16'h7C00;
    step();
    networkDone = 1'b0;
    step();
    tests++; if (dut.dvmem_p1 !== 3'sd2) begin failed++; $display("FAIL sat_dvmem: got %0d want 2", dut.dvmem_p1); end
    step();
    tests++; if (dut.vmem_q !== 16'sh7FFF) begin failed++; $display("FAIL sat_vmem: got %0d want 32767", dut.vmem_q); end
    step();
    tests++; if (spike_out !== 2'b00) begin failed++; $display("FAIL posinf_fire: got %b want 00", spike_out); end
    // src 65 is out of range: J must be 0 even though Q[1] is +1
    networkDone = 1'b1; spike_in = {2'b10, 10'd65}; mu_in = 16'hFC00;
    step();
    networkDone = 1'b0;
    step();
    tests++; if (dut.dvmem_p1 !== 3'sd0) begin failed++; $display("FAIL oor_dvmem: got %0d want 0", dut.dvmem_p1); end
    step(); step();
    tests++; if (spike_out !== 2'b10) begin failed++; $display("FAIL neginf_fire: got %b want 10", spike_out); end
  endtask

  task automatic test_reset_midop();
    networkDone = 1'b1; spike_in = {2'b01, 10'd1}; mu_in = 16'h5678;
    step();
    networkDone = 1'b0;
    tests++; if (dut.state !== S_RECV1) begin failed++; $display("FAIL mid_pre_state: got %0d want %0d", dut.state, S_RECV1); end
    reset_l = 1'b1;
    step();
    tests++; if (dut.state !== S_IDLE) begin failed++; $display("FAIL mid_state: got %0d want %0d", dut.state, S_IDLE); end
    tests++; if (dut.vmem_q !== 16'sd0 || dut.spin_q !== 1'b0 || dut.neuron_id_q !== 10'd0) begin failed++; $display("FAIL mid_regs: got %0d/%b/%h want 0/0/000", dut.vmem_q, dut.spin_q, dut.neuron_id_q); end
    tests++; if (mu_out !== 16'h0 || spike_out !== 2'b00 || neuronWrDone !== 1'b0) begin failed++; $display("FAIL mid_outs: got %h/%b/%b want 0000/00/0", mu_out, spike_out, neuronWrDone); end
    tests++; if (dut.q_mem[13] !== 2'b00 || dut.cnt !== 6'd0) begin failed++; $display("FAIL mid_q: got %b/%0d want 00/0", dut.q_mem[13], dut.cnt); end
    reset_l = 1'b0;
  endtask

  initial begin
    tests = 0;
    failed = 0;
    test_reset();
    test_config();
    test_wrq();
    test_emit();
    test_recv_neg();
    test_self_spike();
    test_saturation();
    test_reset_midop();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
